fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. It owns the program-counter register and captures the two instruction-memory read words into the decoder's `instr` and `N` inputs. It applies the decoder's `cnt_en`, `pc_sload` and `new_pc` back onto the PC, and injects NOP/STP words to prime, halt and resume the pipeline. The instruction memory is synchronous dual-port: the decoder's `instr_addr1`/`instr_addr2` are sampled at a clock edge, and `instr_q1`/`instr_q2` are valid after that edge.

## Interface
Parameters:
- `NOP_WORD`, 16'h0000: encoding injected as a bubble (opcode 00000).
- `STP_WORD`, 16'hF800: encoding injected to hold the pipeline (opcode 11111).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cnt_en` in 1: from decoder; increment PC.
- `pc_sload` in 1: from decoder; load `new_pc`. Has priority over `cnt_en`.
- `new_pc` in 16: from decoder.
- `instr_q1` in 16: instruction memory port 1 read data (current instruction).
- `instr_q2` in 16: instruction memory port 2 read data (following word / immediate).
- `resume` in 1: single-cycle pulse that leaves HALT.
- `bp_en` in 1: breakpoint enable (only when `FETCH_BREAKPOINT_EN`).
- `bp_addr` in 16: breakpoint instruction address (only when `FETCH_BREAKPOINT_EN`).
- `pc` out 16: PC register, to decoder.
- `instr` out 16: instruction word, to decoder.
- `N` out 16: immediate word, to decoder.
- `halted` out 1: high while in HALT.
- `instr_count` out 16: retired-instruction counter.

## Operation
- Invariant in RUN: `pc` = address of current instruction + 1. `instr_q1` = mem[pc-1] and `instr_q2` = mem[pc].
- States: PRIME, RUN, SKIP, HALT.
- PRIME is entered on reset. It drives `instr`=NOP_WORD and `N`=0, so the decoder addresses 0 and 1 and asserts `cnt_en`. Next state is RUN.
- RUN drives `instr`=`instr_q1` and `N`=`instr_q2`.
  - If `instr_q1[15:11]`=5'b11111, next state is HALT and the halt cause is STP.
  - Only opcode 11111 is detected. Other illegal opcodes are not detected here.
- HALT drives `instr`=STP_WORD and `N`=0, so the decoder re-addresses pc-1/pc and the memory keeps returning the halted instruction. The PC is frozen regardless of inputs.
- `resume` in HALT:
  - cause STP: go to SKIP.
  - cause BP: go to RUN with the breakpoint masked for the first RUN cycle.
  - `resume` outside HALT is ignored.
- SKIP drives `instr`=NOP_WORD and `N`=0. The decoder then advances the PC past the STP, and the next state is RUN.
- PC update on every clock edge, except in HALT:
  - if `pc_sload`: PC ← `new_pc`.
  - else if `cnt_en`: PC ← `pc`+1.
  - else: PC holds.
  - Arithmetic is modulo 2^16, so 16'hFFFF+1 wraps to 0.
- `instr_count` increments in RUN cycles where (`cnt_en`|`pc_sload`) is high and no breakpoint is forced. It wraps 16'hFFFF→0.
- Reset values: `pc`=0, state PRIME, `instr_count`=0, `halted`=0, `instr`=NOP_WORD, `N`=0, halt cause STP, breakpoint mask 0.

## Timing
- `instr`, `N` and `halted` are combinational from the state and the memory data. `pc` and `instr_count` are registered.
- Fetch latency is 1 cycle: an address sampled at edge k produces an instruction at the decoder in cycle k+1.
- Reset → first real instruction (mem[0]) at the decoder: 2 cycles after reset deasserts (PRIME, then RUN).
- STP in RUN: the STP is decoded in that cycle (decoder holds). `halted`=1 from the next cycle.
- Resume from STP: SKIP for 1 cycle, then the next instruction (mem[pc]) is in RUN.
- Reset asserted mid-operation (in any state) takes effect at the next edge.
- `reset` and `resume` in the same cycle: reset wins.

## Configuration
- `FETCH_BREAKPOINT_EN` defined:
  - `bp_en` and `bp_addr` ports, the halt-cause register and the mask register are present.
  - In RUN, when `bp_en` && (`pc`-1)==`bp_addr` && !mask, `instr` is forced to STP_WORD that cycle. The next state is HALT and the cause is BP.
  - The mask clears after one RUN cycle.
- Undefined: ports and registers are absent, and HALT is entered only via STP (cause is always STP).

## Structure
- Package `fetch_pkg`:
  - state enum (PRIME, RUN, SKIP, HALT).
  - halt-cause enum (STP, BP).
  - STP opcode constant 5'b11111.
  - NOP_WORD and STP_WORD constants.
- One sub-module, `pc_counter`: 16-bit register with synchronous reset, hold, load priority and increment.

## Test plan
- Reset, memory 0:NOP, 1:NOP → `instr`=0000 in PRIME, then mem[0] in RUN. `pc` goes 0→1→2; `instr_count`=1 after the first RUN cycle.
- CALL at 0 with N=0x0040 (decoder asserts `pc_sload`, `new_pc`=0x0041) → next cycle `pc`=0x0041, `instr`=mem[0x40].
- STP at address 5 → `halted`=1 and `pc` stays 6 for 10 cycles. Pulse `resume` → one NOP cycle, then `instr`=mem[6] and `pc`=7.
- `pc`=16'hFFFF with `cnt_en` → `pc`=0. Counter preset to FFFF + one retire → `instr_count`=0.
- Breakpoint (macro on): `bp_addr`=3, `bp_en`=1 → HALT with `pc`=4 and mem[3] not counted. `resume` → mem[3] executes once and `pc`=5.
- Reset asserted while in HALT and in SKIP, and reset+`resume` in the same cycle → PRIME, `pc`=0, `halted`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   state_t  : fetch sequencing states (PRIME, RUN, SKIP, HALT)
//   cause_t  : reason the fetch stage is sitting in HALT
//   STP_OPCODE, NOP_WORD_DEF, STP_WORD_DEF : instruction encodings
//   is_stp() : opcode-field test for the STP instruction
package fetch_pkg;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    SKIP  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic {
    CAUSE_STP = 1'b0,
    CAUSE_BP  = 1'b1
  } cause_t;

  localparam logic [4:0]  STP_OPCODE   = 5'b11111;
  localparam logic [15:0] NOP_WORD_DEF = 16'h0000;
  localparam logic [15:0] STP_WORD_DEF = 16'hF800;

  function automatic logic is_stp(input logic [15:0] word);
    return word[15:11] == STP_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: DATA_W-bit register with synchronous active-high reset,
// hold, load and increment (load has priority over increment, hold over both).
//   clk      in  : clock, rising edge
//   reset    in  : synchronous reset to zero
//   hold     in  : freeze the register
//   load     in  : load load_val
//   inc      in  : increment by one (modulo 2^DATA_W)
//   load_val in  : value for load
//   q        out : register value
module pc_counter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              load,
  input  logic              inc,
  input  logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (!hold) begin
      if (load) begin
        q <= load_val;
      end else if (inc) begin
        q <= q + DATA_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the decoder. Owns the PC,
// presents the two synchronous instruction-memory read words to the decoder
// as instr/N, and injects NOP/STP words to prime, halt and resume.
//
// Optional feature macro: FETCH_BREAKPOINT_EN (adds bp_en/bp_addr, the
// halt-cause register and the one-cycle breakpoint mask).
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   cnt_en, pc_sload  : PC increment / load requests from the decoder
//   new_pc            : PC load value from the decoder
//   instr_q1/instr_q2 : memory words at pc-1 and pc
//   resume            : one-cycle pulse that leaves HALT
//   bp_en, bp_addr    : breakpoint enable / instruction address (macro only)
//   pc                : PC register (current instruction address + 1)
//   instr, N          : instruction and immediate words to the decoder
//   halted            : high while in HALT
//   instr_count       : retired-instruction counter
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEF,
  parameter logic [15:0] STP_WORD = STP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_en,
  input  logic        pc_sload,
  input  logic [15:0] new_pc,
  input  logic [15:0] instr_q1,
  input  logic [15:0] instr_q2,
  input  logic        resume,
`ifdef FETCH_BREAKPOINT_EN
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
`endif
  output logic [15:0] pc,
  output logic [15:0] instr,
  output logic [15:0] N,
  output logic        halted,
  output logic [15:0] instr_count
);

  state_t state, state_nx;
  logic   bp_hit;
  logic   retire;

`ifdef FETCH_BREAKPOINT_EN
  cause_t      cause, cause_nx;
  logic        mask, mask_nx;
  logic [15:0] cur_addr;

  // pc runs one ahead of the instruction being presented in RUN
  assign cur_addr = pc - 16'd1;
  assign bp_hit   = (state == RUN) && bp_en && (cur_addr == bp_addr) && !mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      cause <= CAUSE_STP;
      mask  <= 1'b0;
    end else begin
      cause <= cause_nx;
      mask  <= mask_nx;
    end
  end
`else
  assign bp_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PRIME;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    instr    = NOP_WORD;
    N        = '0;
`ifdef FETCH_BREAKPOINT_EN
    cause_nx = cause;
    mask_nx  = mask;
`endif
    case (state)
      // Bubble so the decoder addresses words 0/1 and steps the PC.
      PRIME: state_nx = RUN;
      RUN: begin
        instr = bp_hit ? STP_WORD : instr_q1;
        N     = instr_q2;
`ifdef FETCH_BREAKPOINT_EN
        mask_nx = 1'b0;
        if (bp_hit) begin
          state_nx = HALT;
          cause_nx = CAUSE_BP;
        end else if (is_stp(instr_q1)) begin
          state_nx = HALT;
          cause_nx = CAUSE_STP;
        end
`else
        if (is_stp(instr_q1)) begin
          state_nx = HALT;
        end
`endif
      end
      // Bubble while the decoder advances the PC past the STP.
      SKIP: state_nx = RUN;
      // STP keeps the decoder re-addressing pc-1/pc, so memory holds steady.
      HALT: begin
        instr = STP_WORD;
        if (resume) begin
`ifdef FETCH_BREAKPOINT_EN
          if (cause == CAUSE_BP) begin
            // Re-execute the breakpointed instruction without re-triggering.
            state_nx = RUN;
            mask_nx  = 1'b1;
          end else begin
            state_nx = SKIP;
          end
`else
          state_nx = SKIP;
`endif
        end
      end
      default: state_nx = PRIME;
    endcase
  end

  assign halted = (state == HALT);
  assign retire = (state == RUN) && (cnt_en || pc_sload) && !bp_hit;

  pc_counter #(.DATA_W(16)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .hold     (state == HALT),
    .load     (pc_sload),
    .inc      (cnt_en),
    .load_val (new_pc),
    .q        (pc)
  );

  pc_counter #(.DATA_W(16)) u_instr_count (
    .clk      (clk),
    .reset    (reset),
    .hold     (1'b0),
    .load     (1'b0),
    .inc      (retire),
    .load_val (16'h0000),
    .q        (instr_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. The bench plays the
// decoder (cnt_en/pc_sload/new_pc) and a synchronous dual-port instruction
// memory whose read data is mem[pc-1]/mem[pc]. Breakpoint sequences are
// built only when FETCH_BREAKPOINT_EN is defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cnt_en;
  logic        pc_sload;
  logic [15:0] new_pc;
  logic [15:0] instr_q1;
  logic [15:0] instr_q2;
  logic        resume;
`ifdef FETCH_BREAKPOINT_EN
  logic        bp_en;
  logic [15:0] bp_addr;
`endif
  logic [15:0] pc;
  logic [15:0] instr;
  logic [15:0] N;
  logic        halted;
  logic [15:0] instr_count;

  logic [15:0] mem [0:65535];

  // standalone counter for the wrap corner of the retire counter
  logic        c_rst, c_hold, c_load, c_inc;
  logic [15:0] c_val, c_q;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst, cen, sld, res;
    logic [15:0] npc;
    logic [15:0] e_pc, e_instr, e_n;
    logic        e_halted;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   step_no = 0;

  always #5 clk = ~clk;

  always_comb begin
    instr_q1 = mem[pc - 16'd1];
    instr_q2 = mem[pc];
  end

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .cnt_en      (cnt_en),
    .pc_sload    (pc_sload),
    .new_pc      (new_pc),
    .instr_q1    (instr_q1),
    .instr_q2    (instr_q2),
    .resume      (resume),
`ifdef FETCH_BREAKPOINT_EN
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
`endif
    .pc          (pc),
    .instr       (instr),
    .N           (N),
    .halted      (halted),
    .instr_count (instr_count)
  );

  pc_counter #(.DATA_W(16)) u_cnt (
    .clk      (clk),
    .reset    (c_rst),
    .hold     (c_hold),
    .load     (c_load),
    .inc      (c_inc),
    .load_val (c_val),
    .q        (c_q)
  );

  function automatic vec_t mk(input logic rst, input logic cen, input logic sld,
                              input logic res, input logic [15:0] npc,
                              input logic [15:0] epc, input logic [15:0] ei,
                              input logic [15:0] en, input logic eh,
                              input logic [15:0] ec);
    vec_t v;
    v.rst = rst; v.cen = cen; v.sld = sld; v.res = res; v.npc = npc;
    v.e_pc = epc; v.e_instr = ei; v.e_n = en; v.e_halted = eh; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Drive one cycle of decoder/control inputs, then compare the DUT state
  // seen in the following cycle against the queued expectation.
  task automatic apply(input vec_t v);
    vec_t e;
    reset    = v.rst;
    cnt_en   = v.cen;
    pc_sload = v.sld;
    resume   = v.res;
    new_pc   = v.npc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    step_no++;
    chk("pc",          step_no, pc,                   e.e_pc);
    chk("instr",       step_no, instr,                e.e_instr);
    chk("N",           step_no, N,                    e.e_n);
    chk("halted",      step_no, {15'd0, halted},      {15'd0, e.e_halted});
    chk("instr_count", step_no, instr_count,          e.e_cnt);
  endtask

  task automatic cnt_step(input logic r, input logic h, input logic l,
                          input logic i, input logic [15:0] val,
                          input logic [15:0] exp);
    c_rst = r; c_hold = h; c_load = l; c_inc = i; c_val = val;
    @(posedge clk);
    #1;
    chk("cnt_unit", 0, c_q, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[5]      = 16'hF800;
    mem[6]      = 16'h1234;
    mem[7]      = 16'h0707;
    mem[8]      = 16'h0808;
    mem[16'hFFFE] = 16'h0EEE;
    mem[16'hFFFF] = 16'h00FF;

    reset = 1'b1; cnt_en = 1'b0; pc_sload = 1'b0; resume = 1'b0; new_pc = '0;
`ifdef FETCH_BREAKPOINT_EN
    bp_en = 1'b0; bp_addr = 16'h0000;
`endif
    c_rst = 1'b1; c_hold = 1'b0; c_load = 1'b0; c_inc = 1'b0; c_val = '0;

    // reset, prime, run to the STP at 5, halt, resume, skip, wrap
    //             rst cen sld res npc       pc        instr     N         h  cnt
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 16'd0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 16'd1));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 0, 16'd2));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0000, 0, 16'd3));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0005, 16'h0000, 16'hF800, 0, 16'd4));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0006, 16'hF800, 16'h1234, 0, 16'd5));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0006, 16'hF800, 16'h0000, 1, 16'd5));
    tbl.push_back(mk(0, 1, 1, 0, 16'h0100, 16'h0006, 16'hF800, 16'h0000, 1, 16'd5));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0006, 16'hF800, 16'h0000, 1, 16'd5));
    tbl.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0006, 16'h0000, 16'h0000, 0, 16'd5));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0007, 16'h1234, 16'h0707, 0, 16'd5));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0008, 16'h0707, 16'h0808, 0, 16'd6));
    tbl.push_back(mk(0, 1, 0, 1, 16'h0000, 16'h0009, 16'h0808, 16'h0000, 0, 16'd7));
    tbl.push_back(mk(0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 16'h0EEE, 16'h00FF, 0, 16'd8));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 0, 16'd9));
    tbl.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 16'd10));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 16'd10));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // CALL at 0 with immediate 0x0040
    mem[0] = 16'h7000; mem[1] = 16'h0040; mem[16'h0040] = 16'hABCD; mem[16'h0041] = 16'h5555;
    apply(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h7000, 16'h0040, 0, 16'd0));
    apply(mk(0, 1, 1, 0, 16'h0041, 16'h0041, 16'hABCD, 16'h5555, 0, 16'd1));

    // counter wrap FFFF -> 0
    cnt_step(1, 0, 0, 0, 16'h0000, 16'h0000);
    cnt_step(0, 0, 1, 1, 16'hFFFF, 16'hFFFF);
    cnt_step(0, 0, 0, 1, 16'h0000, 16'h0000);
    cnt_step(0, 1, 1, 1, 16'h1234, 16'h0000);
    cnt_step(0, 0, 0, 1, 16'h0000, 16'h0001);

`ifdef FETCH_BREAKPOINT_EN
    // breakpoint on address 3
    mem[0] = 16'h0000; mem[1] = 16'h0000; mem[3] = 16'h2222; mem[4] = 16'h4444;
    bp_en = 1'b1; bp_addr = 16'h0003;
    apply(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 16'd0));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 0, 16'd1));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0003, 16'h0000, 16'h2222, 0, 16'd2));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0004, 16'hF800, 16'h4444, 0, 16'd3));
    apply(mk(0, 0, 0, 0, 16'h0000, 16'h0004, 16'hF800, 16'h0000, 1, 16'd3));
    apply(mk(0, 0, 0, 0, 16'h0000, 16'h0004, 16'hF800, 16'h0000, 1, 16'd3));
    apply(mk(0, 0, 0, 1, 16'h0000, 16'h0004, 16'h2222, 16'h4444, 0, 16'd3));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0005, 16'h4444, 16'hF800, 0, 16'd4));
    apply(mk(0, 0, 0, 0, 16'h0000, 16'h0005, 16'h4444, 16'hF800, 0, 16'd4));
    bp_en = 1'b0;
`endif

    // reset while in HALT, in SKIP, and together with resume
    mem[0] = 16'hF800; mem[1] = 16'h1111;
    apply(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 16'hF800, 16'h1111, 0, 16'd0));
    apply(mk(0, 0, 0, 0, 16'h0000, 16'h0001, 16'hF800, 16'h0000, 1, 16'd0));
    apply(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 16'hF800, 16'h1111, 0, 16'd0));
    apply(mk(0, 0, 0, 0, 16'h0000, 16'h0001, 16'hF800, 16'h0000, 1, 16'd0));
    apply(mk(0, 0, 0, 1, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 16'd0));
    apply(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 16'hF800, 16'h1111, 0, 16'd0));
    apply(mk(0, 0, 0, 0, 16'h0000, 16'h0001, 16'hF800, 16'h0000, 1, 16'd0));
    apply(mk(1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0));
    apply(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 16'hF800, 16'h1111, 0, 16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
